// File: rtl/adc_capture_hls_deadlock_pkg.sv
// Shared types and helpers for the deadlock report collector and the process units.
package adc_capture_hls_deadlock_pkg;

  // Upper bound on process-vector width accepted by the helper functions.
  localparam int unsigned MaxProcs = 32;

  typedef enum logic [2:0] {
    StIdle,
    StOrigin,
    StTrace,
    StClear,
    StDone
  } dl_state_e;

  // Process-ID width needed to name n processes (at least one bit).
  function automatic int unsigned proc_id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set(input logic [MaxProcs-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MaxProcs - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_capture_hls_deadlock_trace_buf.sv
// Trace register file: records visited process IDs, owns the entry count and overflow.
module adc_capture_hls_deadlock_trace_buf #(
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned PROC_ID_W   = 2,
  parameter int unsigned LenW        = $clog2(TRACE_DEPTH + 1),
  parameter int unsigned AddrW       = $clog2(TRACE_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 init_i,
  input  logic                 push_i,
  input  logic                 clear_i,
  input  logic [PROC_ID_W-1:0] wdata_i,
  input  logic [AddrW-1:0]     raddr_i,
  output logic [PROC_ID_W-1:0] rdata_o,
  output logic [LenW-1:0]      len_o,
  output logic                 overflow_o
);

  logic [PROC_ID_W-1:0] mem_q [TRACE_DEPTH];
  logic [LenW-1:0]      len_q;
  logic                 overflow_q;
  logic [PROC_ID_W-1:0] last_entry;

  // Pushes only happen once the origin entry exists, so len_q >= 1 here.
  assign last_entry = mem_q[AddrW'(len_q - LenW'(1))];

  // Entry 0 is written on init; later pushes append only when the holder changed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) mem_q[i] <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else if (init_i) begin
      mem_q[0] <= wdata_i;
      len_q    <= LenW'(1);
    end else if (push_i && (wdata_i != last_entry)) begin
      if (len_q < LenW'(TRACE_DEPTH)) begin
        mem_q[AddrW'(len_q)] <= wdata_i;
        len_q                <= len_q + LenW'(1);
      end else begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign len_o      = len_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/adc_capture_hls_deadlock_report_unit.sv
// Deadlock report collector: nominates an origin, follows the token round the
// dependency cycle, records the path and latches the result until rearmed.
module adc_capture_hls_deadlock_report_unit
  import adc_capture_hls_deadlock_pkg::*;
#(
  parameter int unsigned PROC_NUM    = 4,
  parameter int unsigned PROC_ID_W   = 2,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [PROC_NUM-1:0]                dl_detect_vec,
  input  logic [PROC_NUM-1:0]                token_hold_vec,
  output logic [PROC_NUM-1:0]                origin_vec,
  output logic                               token_clear,
  output logic                               deadlock_flag,
  output logic                               timeout_flag,
  output logic                               overflow_flag,
  output logic                               branch_flag,
  output logic [$clog2(TRACE_DEPTH+1)-1:0]   trace_len,
  input  logic [$clog2(TRACE_DEPTH)-1:0]     trace_raddr,
  output logic [PROC_ID_W-1:0]               trace_rdata,
  input  logic                               rearm
);

  localparam int unsigned LenW  = $clog2(TRACE_DEPTH + 1);
  localparam int unsigned AddrW = $clog2(TRACE_DEPTH);

  dl_state_e            state_q;
  logic [PROC_ID_W-1:0] org_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [PROC_NUM-1:0]  origin_q;
  logic                 clear_q;
  logic                 deadlock_q;
  logic                 timeout_q;
  logic                 branch_q;

  logic [PROC_ID_W-1:0] det_idx;
  logic [PROC_ID_W-1:0] hold_idx;
  logic                 hold_any;
  logic                 hold_multi;
  logic                 org_held;
  logic [CNT_W-1:0]     cnt_inc;

  logic                 buf_init;
  logic                 buf_push;
  logic                 buf_clear;
  logic [PROC_ID_W-1:0] buf_wdata;

  assign det_idx    = PROC_ID_W'(lowest_set(MaxProcs'(dl_detect_vec)));
  assign hold_idx   = PROC_ID_W'(lowest_set(MaxProcs'(token_hold_vec)));
  assign hold_any   = |token_hold_vec;
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign hold_multi = |(token_hold_vec & (token_hold_vec - PROC_NUM'(1)));
  assign org_held   = token_hold_vec[org_q];
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // Trace buffer controls decoded from the current state.
  always_comb begin
    buf_init  = (state_q == StIdle) && (|dl_detect_vec);
    buf_push  = (state_q == StTrace) && !org_held && hold_any;
    buf_clear = (state_q == StDone) && rearm;
    buf_wdata = buf_init ? det_idx : hold_idx;
  end

  // Report FSM with registered strobes and flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      org_q      <= '0;
      cnt_q      <= '0;
      origin_q   <= '0;
      clear_q    <= 1'b0;
      deadlock_q <= 1'b0;
      timeout_q  <= 1'b0;
      branch_q   <= 1'b0;
    end else begin
      origin_q <= '0;
      clear_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|dl_detect_vec) begin
            org_q    <= det_idx;
            origin_q <= PROC_NUM'(1) << det_idx;
            state_q  <= StOrigin;
          end
        end
        StOrigin: begin
          cnt_q   <= '0;
          state_q <= StTrace;
        end
        StTrace: begin
          if (org_held) begin
            clear_q <= 1'b1;
            state_q <= StClear;
          end else if (!hold_any) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_W'(TIMEOUT)) begin
              timeout_q <= 1'b1;
              clear_q   <= 1'b1;
              state_q   <= StClear;
            end
          end else begin
            cnt_q <= '0;
            if (hold_multi) branch_q <= 1'b1;
          end
        end
        StClear: begin
          deadlock_q <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          if (rearm) begin
            deadlock_q <= 1'b0;
            timeout_q  <= 1'b0;
            branch_q   <= 1'b0;
            org_q      <= '0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  adc_capture_hls_deadlock_trace_buf #(
    .TRACE_DEPTH(TRACE_DEPTH),
    .PROC_ID_W  (PROC_ID_W),
    .LenW       (LenW),
    .AddrW      (AddrW)
  ) u_trace_buf (
    .clock     (clock),
    .reset     (reset),
    .init_i    (buf_init),
    .push_i    (buf_push),
    .clear_i   (buf_clear),
    .wdata_i   (buf_wdata),
    .raddr_i   (trace_raddr),
    .rdata_o   (trace_rdata),
    .len_o     (trace_len),
    .overflow_o(overflow_flag)
  );

  assign origin_vec    = origin_q;
  assign token_clear   = clear_q;
  assign deadlock_flag = deadlock_q;
  assign timeout_flag  = timeout_q;
  assign branch_flag   = branch_q;

endmodule

// File: tb/tb_adc_capture_hls_deadlock_report_unit.sv
// Bench for the deadlock report collector: directed scenarios plus random rings,
// checked against a list-based model of the report rules.
module tb_adc_capture_hls_deadlock_report_unit;

  localparam int TIMEOUT = 64;
  localparam int DEPTH   = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] dl_detect_vec = '0, token_hold_vec = '0;
  logic [3:0] origin_vec;
  logic       token_clear, deadlock_flag, timeout_flag, overflow_flag, branch_flag;
  logic [3:0] trace_len;
  logic [2:0] trace_raddr = '0;
  logic [1:0] trace_rdata;
  logic       rearm = 1'b0;

  // Second instance with a two-entry trace for the overflow scenario.
  logic [3:0] dl2 = '0, hold2 = '0;
  logic [3:0] origin2;
  logic       clear2, dead2, tout2, ovf2, br2;
  logic [1:0] len2;
  logic       raddr2 = 1'b0;
  logic [1:0] rdata2;
  logic       rearm2 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] seq[$];
  bit         pulse_rearm = 0;

  always #5 clock = ~clock;

  adc_capture_hls_deadlock_report_unit #(
    .PROC_NUM(4), .PROC_ID_W(2), .TRACE_DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(7)
  ) dut (
    .clock(clock), .reset(reset), .dl_detect_vec(dl_detect_vec),
    .token_hold_vec(token_hold_vec), .origin_vec(origin_vec), .token_clear(token_clear),
    .deadlock_flag(deadlock_flag), .timeout_flag(timeout_flag),
    .overflow_flag(overflow_flag), .branch_flag(branch_flag), .trace_len(trace_len),
    .trace_raddr(trace_raddr), .trace_rdata(trace_rdata), .rearm(rearm)
  );

  adc_capture_hls_deadlock_report_unit #(
    .PROC_NUM(4), .PROC_ID_W(2), .TRACE_DEPTH(2), .TIMEOUT(TIMEOUT), .CNT_W(7)
  ) dut2 (
    .clock(clock), .reset(reset), .dl_detect_vec(dl2), .token_hold_vec(hold2),
    .origin_vec(origin2), .token_clear(clear2), .deadlock_flag(dead2),
    .timeout_flag(tout2), .overflow_flag(ovf2), .branch_flag(br2), .trace_len(len2),
    .trace_raddr(raddr2), .trace_rdata(rdata2), .rearm(rearm2)
  );

  function automatic int low_bit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int popcnt(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    dl_detect_vec = '0; token_hold_vec = '0; rearm = 1'b0;
    dl2 = '0; hold2 = '0; rearm2 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Drive one full report on dut: detect, then the holder sequence in seq.
  task automatic run_report(input string name, input logic [3:0] det);
    int   org, idle, h;
    bit   stopped, e_to, e_br, e_ovf;
    int   exp_tr[$];
    org = low_bit(det);
    exp_tr = {org};
    idle = 0; stopped = 0; e_to = 0; e_br = 0; e_ovf = 0;
    @(negedge clock);
    dl_detect_vec = det;
    token_hold_vec = '0;
    @(negedge clock);
    n_cmp++;
    if (origin_vec !== 4'(1 << org)) begin
      n_bad++;
      $display("FAIL %s origin_vec: got %b want %b", name, origin_vec, 4'(1 << org));
    end
    dl_detect_vec = '0;
    @(negedge clock);
    n_cmp++;
    if (origin_vec !== 4'b0) begin
      n_bad++;
      $display("FAIL %s origin_pulse_len: got %b want 0000", name, origin_vec);
    end
    foreach (seq[i]) begin
      token_hold_vec = seq[i];
      rearm = pulse_rearm && (i == 0);
      if (seq[i][org]) begin
        stopped = 1;
      end else if (seq[i] == 4'b0) begin
        idle++;
        if (idle == TIMEOUT) begin
          e_to = 1;
          stopped = 1;
        end
      end else begin
        idle = 0;
        h = low_bit(seq[i]);
        if (popcnt(seq[i]) > 1) e_br = 1;
        if (h != exp_tr[$]) begin
          if (exp_tr.size() < DEPTH) exp_tr.push_back(h);
          else e_ovf = 1;
        end
      end
      @(negedge clock);
      rearm = 1'b0;
      n_cmp++;
      if (token_clear !== stopped) begin
        n_bad++;
        $display("FAIL %s token_clear step %0d: got %b want %b", name, i, token_clear, stopped);
      end
      if (stopped) break;
    end
    token_hold_vec = '0;
    if (!stopped) begin
      n_bad++;
      $display("FAIL %s model_never_closed: got open want closed", name);
    end
    @(negedge clock);
    n_cmp++;
    if ({token_clear, deadlock_flag, timeout_flag, branch_flag, overflow_flag}
        !== {1'b0, 1'b1, e_to, e_br, e_ovf}) begin
      n_bad++;
      $display("FAIL %s clr/dl/to/br/ovf: got %b%b%b%b%b want 0 1 %b %b %b", name, token_clear,
               deadlock_flag, timeout_flag, branch_flag, overflow_flag, e_to, e_br, e_ovf);
    end
    n_cmp++;
    if (trace_len !== 4'(exp_tr.size())) begin
      n_bad++;
      $display("FAIL %s trace_len: got %0d want %0d", name, trace_len, exp_tr.size());
    end
    foreach (exp_tr[i]) begin
      trace_raddr = 3'(i);
      #1;
      n_cmp++;
      if (trace_rdata !== 2'(exp_tr[i])) begin
        n_bad++;
        $display("FAIL %s trace[%0d]: got %0d want %0d", name, i, trace_rdata, exp_tr[i]);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({origin_vec, token_clear, deadlock_flag, timeout_flag, overflow_flag, branch_flag,
         trace_len} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b%b%b%b%b%b%b want all zero", origin_vec, token_clear,
               deadlock_flag, timeout_flag, overflow_flag, branch_flag, trace_len);
    end
    for (int i = 0; i < DEPTH; i++) begin
      trace_raddr = 3'(i);
      #1;
      n_cmp++;
      if (trace_rdata !== 2'b0) begin
        n_bad++;
        $display("FAIL reset_trace[%0d]: got %0d want 0", i, trace_rdata);
      end
    end
  endtask

  task automatic test_ring();
    apply_reset();
    seq = {4'b0100, 4'b0010, 4'b0001};
    run_report("ring", 4'b0001);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    seq = {4'b0100, 4'b1000, 4'b0010};
    run_report("simul", 4'b1010);
  endtask

  task automatic test_timeout();
    apply_reset();
    seq = {};
    for (int i = 0; i < TIMEOUT + 4; i++) seq.push_back(4'b0000);
    run_report("timeout", 4'b0100);
  endtask

  task automatic test_overflow_branch();
    logic [3:0] hs[4];
    apply_reset();
    hs = '{4'b0100, 4'b1010, 4'b0100, 4'b0001};
    @(negedge clock);
    dl2 = 4'b0001;
    @(negedge clock);
    n_cmp++;
    if (origin2 !== 4'b0001) begin
      n_bad++;
      $display("FAIL ovf origin_vec: got %b want 0001", origin2);
    end
    dl2 = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      hold2 = hs[i];
    end
    @(negedge clock);
    hold2 = '0;
    n_cmp++;
    if (clear2 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf token_clear: got %b want 1", clear2);
    end
    @(negedge clock);
    raddr2 = 1'b0;
    #1;
    n_cmp++;
    if ({dead2, br2, ovf2, tout2, len2, rdata2} !== {1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0}) begin
      n_bad++;
      $display("FAIL ovf dl/br/ovf/to/len/t0: got %b %b %b %b %0d %0d want 1 1 1 0 2 0",
               dead2, br2, ovf2, tout2, len2, rdata2);
    end
    raddr2 = 1'b1;
    #1;
    n_cmp++;
    if (rdata2 !== 2'd2) begin
      n_bad++;
      $display("FAIL ovf trace[1]: got %0d want 2", rdata2);
    end
  endtask

  task automatic test_rearm();
    apply_reset();
    seq = {4'b1000, 4'b0100, 4'b0001};
    pulse_rearm = 1;
    run_report("rearm_in_trace", 4'b0011);
    pulse_rearm = 0;
    @(negedge clock);
    rearm = 1'b1;
    dl_detect_vec = 4'b0001;
    @(negedge clock);
    rearm = 1'b0;
    n_cmp++;
    if ({deadlock_flag, timeout_flag, branch_flag, overflow_flag, trace_len, origin_vec}
        !== '0) begin
      n_bad++;
      $display("FAIL rearm_clear: got %b %b %b %b %0d %b want all zero", deadlock_flag,
               timeout_flag, branch_flag, overflow_flag, trace_len, origin_vec);
    end
    @(negedge clock);
    dl_detect_vec = '0;
    n_cmp++;
    if (origin_vec !== 4'b0001) begin
      n_bad++;
      $display("FAIL rearm_then_origin: got %b want 0001", origin_vec);
    end
  endtask

  task automatic test_reset_mid_trace();
    apply_reset();
    @(negedge clock);
    dl_detect_vec = 4'b0010;
    @(negedge clock);
    dl_detect_vec = '0;
    @(negedge clock);
    token_hold_vec = 4'b1100;
    @(negedge clock);
    token_hold_vec = 4'b0100;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({origin_vec, token_clear, deadlock_flag, timeout_flag, overflow_flag, branch_flag,
         trace_len} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %b %b %b %b %b %b %0d want all zero", origin_vec,
               token_clear, deadlock_flag, timeout_flag, overflow_flag, branch_flag, trace_len);
    end
    token_hold_vec = '0;
    @(negedge clock);
    reset = 1'b1;
    seq = {4'b0001, 4'b0100};
    run_report("after_reset", 4'b0100);
  endtask

  task automatic test_random();
    logic [3:0] det, v;
    int         org, n;
    for (int r = 0; r < 25; r++) begin
      apply_reset();
      det = 4'($urandom_range(1, 15));
      org = low_bit(det);
      seq = {};
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) v = 4'b0;
        else v = 4'($urandom_range(0, 15)) & ~4'(1 << org);
        seq.push_back(v);
      end
      seq.push_back(4'(1 << org) | 4'($urandom_range(0, 15)));
      run_report($sformatf("rand%0d", r), det);
    end
  endtask

  initial begin
    test_reset();
    test_ring();
    test_simultaneous();
    test_timeout();
    test_overflow_branch();
    test_rearm();
    test_reset_mid_trace();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
